// File: rtl/adc081c021_read_vol.sv
// I2C master: reads one conversion result from a TI ADC081C021 per trigger pulse.
// Define ADC081C021_ACK_CHECK_EN to abort on a slave NACK of the address byte.
module adc081c021_read_vol #(
  parameter int         sys_clk_freq  = 50_000_000,
  parameter int         i2c_clk_speed = 400_000,
  parameter logic [6:0] dev_addr      = 7'h54
) (
  input  logic       sclk,
  input  logic       nrst,
  input  logic       read_trigger,
  output logic       read_done,
  output logic [7:0] voltage,
  output logic       scl,
  inout  logic       sda
);

  localparam int Q  = sys_clk_freq / (i2c_clk_speed * 4);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] QMAX = QW'(Q - 1);
  localparam logic [7:0] ADDR_BYTE = {dev_addr, 1'b1};

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] ADDR   = 4'd2;
  localparam logic [3:0] ACK_A  = 4'd3;
  localparam logic [3:0] RD_MSB = 4'd4;
  localparam logic [3:0] MACK   = 4'd5;
  localparam logic [3:0] RD_LSB = 4'd6;
  localparam logic [3:0] MNACK  = 4'd7;
  localparam logic [3:0] STOP   = 4'd8;
  localparam logic [3:0] DONE   = 4'd9;

  logic [3:0]    state;
  logic [3:0]    state_n;
  logic [QW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx;
  logic          sda_low;

  logic busy;
  logic data_slot;
  logic q_end;
  logic slot_end;
  logic q1_start;
  logic q2_start;
  logic sample;

  assign busy      = (state != IDLE) && (state != DONE);
  assign data_slot = (state >= ADDR) && (state <= MNACK);
  assign q_end     = (qcnt == QMAX);
  assign slot_end  = q_end && (qtr == 2'd3);
  assign q1_start  = q_end && (qtr == 2'd0);
  assign q2_start  = q_end && (qtr == 2'd1);
  assign sample    = q_end && (qtr == 2'd2);

`ifdef ADC081C021_ACK_CHECK_EN
  logic nack;

  always_ff @(posedge sclk or posedge nrst) begin
    if (nrst) begin
      nack <= 1'b0;
    end else if (sample && state == ACK_A) begin
      nack <= sda;
    end
  end
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (read_trigger) state_n = START;
      START:  if (slot_end) state_n = ADDR;
      ADDR:   if (slot_end && bit_cnt == 3'd7) state_n = ACK_A;
      ACK_A: begin
        if (slot_end) begin
`ifdef ADC081C021_ACK_CHECK_EN
          state_n = nack ? STOP : RD_MSB;
`else
          state_n = RD_MSB;
`endif
        end
      end
      RD_MSB: if (slot_end && bit_cnt == 3'd7) state_n = MACK;
      MACK:   if (slot_end) state_n = RD_LSB;
      RD_LSB: if (slot_end && bit_cnt == 3'd7) state_n = MNACK;
      MNACK:  if (slot_end) state_n = STOP;
      STOP:   if (slot_end) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge nrst) begin
    if (nrst) begin
      state   <= IDLE;
      qcnt    <= '0;
      qtr     <= 2'd0;
      bit_cnt <= 3'd0;
    end else begin
      state <= state_n;
      if (!busy) begin
        qcnt <= '0;
        qtr  <= 2'd0;
      end else begin
        qcnt <= q_end ? '0 : qcnt + 1'b1;
        if (q_end) qtr <= qtr + 2'd1;
      end
      // wraps 7->0 as the last bit of a byte hands over to an ACK slot
      if (slot_end && (state == ADDR || state == RD_MSB || state == RD_LSB))
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // only LSB[7:4] is shifted in, leaving rx = {MSB[3:0], LSB[7:4]}
  always_ff @(posedge sclk or posedge nrst) begin
    if (nrst) begin
      rx <= 8'h00;
    end else if (sample) begin
      if (state == RD_MSB || (state == RD_LSB && !bit_cnt[2]))
        rx <= {rx[6:0], sda};
    end
  end

  always_ff @(posedge sclk or posedge nrst) begin
    if (nrst) begin
      sda_low <= 1'b0;
    end else if (state != STOP && state_n == STOP) begin
      sda_low <= 1'b1;
    end else begin
      unique case (state)
        START:  if (q2_start) sda_low <= 1'b1;
        ADDR:   if (q1_start) sda_low <= ~ADDR_BYTE[~bit_cnt];
        MACK:   if (q1_start) sda_low <= 1'b1;
        ACK_A, RD_MSB,
        RD_LSB, MNACK: if (q1_start) sda_low <= 1'b0;
        STOP:   if (q2_start) sda_low <= 1'b0;
        default: sda_low <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge nrst) begin
    if (nrst) begin
      read_done <= 1'b0;
      voltage   <= 8'h00;
    end else begin
      read_done <= (state == DONE);
      if (state == DONE) begin
`ifdef ADC081C021_ACK_CHECK_EN
        if (!nack) voltage <= rx;
`else
        voltage <= rx;
`endif
      end
    end
  end

  always_comb begin
    scl = 1'b1;
    if (data_slot) scl = qtr[1];
    else if (state == STOP) scl = (qtr != 2'd0);
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_adc081c021_read_vol.sv
// Bench for adc081c021_read_vol: slave model, bus monitor and done scoreboard.
// Adds a slave-NACK step when ADC081C021_ACK_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_adc081c021_read_vol;

  localparam int LAT_FULL = 3597;
  localparam int LAT_NACK = 1365;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       done;
  logic [7:0] vol;
  logic       scl;
  wire        sda_w;
  logic       slave_low = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  adc081c021_read_vol dut (
    .sclk         (clk),
    .nrst         (rst),
    .read_trigger (trig),
    .read_done    (done),
    .voltage      (vol),
    .scl          (scl),
    .sda          (sda_w)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dones = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] v;
    int         due;
  } exp_t;
  exp_t sbq[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  s_msb = 8'h00;
  logic [7:0]  s_lsb = 8'h00;
  logic        s_ack = 1'b1;
  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;
  logic        in_tx = 1'b0;
  int          nb = 0;
  logic [27:0] bits = '0;

  function automatic logic slave_bit(int k);
    if (!s_ack) return 1'b0;
    if (k == 9) return 1'b1;
    if (k >= 10 && k <= 17) return !s_msb[17-k];
    if (k >= 19 && k <= 26) return !s_lsb[26-k];
    return 1'b0;
  endfunction

  // slave model and bus monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (p_scl && scl && p_sda && !sda_w) begin
      in_tx = 1'b1;
      nb    = 0;
      bits  = '0;
    end else if (in_tx && !p_scl && scl) begin
      if (nb < 28) bits[nb] = sda_w;
      nb++;
    end else if (in_tx && p_scl && !scl) begin
      slave_low = slave_bit(nb + 1);
    end else if (in_tx && p_scl && scl && !p_sda && sda_w) begin
      in_tx = 1'b0;
      check("bus_addr", {bits[0], bits[1], bits[2], bits[3],
                         bits[4], bits[5], bits[6], bits[7]}, 8'hA9);
      if (s_ack) begin
        check("bus_nbits", nb, 28);
        check("bus_slave_ack", bits[8], 1'b0);
        check("bus_mack", bits[17], 1'b0);
        check("bus_mnack", bits[26], 1'b1);
      end else begin
        check("bus_nbits_nack", nb, 10);
        check("bus_slave_nack", bits[8], 1'b1);
      end
    end
    p_scl = scl;
    p_sda = sda_w;
  end

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      dones++;
      check("done_expected", sbq.size() != 0, 1'b1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("done_latency", cyc, e.due);
        check("done_voltage", vol, e.v);
      end
    end
  end

  task automatic fire(logic push, logic [7:0] v, int lat);
    @(negedge clk);
    trig = 1'b1;
    if (push) sbq.push_back('{v: v, due: cyc + 1 + lat});
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sbq.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  int d0;

  initial begin
    #15;
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda_w, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_voltage", vol, 8'h00);
    #5 rst = 1'b0;
    repeat (5) @(negedge clk);

    s_msb = 8'h0A; s_lsb = 8'hB0;
    fire(1'b1, 8'hAB, LAT_FULL);
    drain(4000);
    check("single_hold", vol, 8'hAB);

    d0 = dones;
    s_msb = 8'h0F; s_lsb = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      fire(1'b1, 8'hFF, LAT_FULL);
      repeat (4998) @(negedge clk);
    end
    drain(100);
    check("periodic_count", dones - d0, 3);

    d0 = dones;
    s_msb = 8'h05; s_lsb = 8'h30;
    fire(1'b1, 8'h53, LAT_FULL);
    repeat (98) @(negedge clk);
    fire(1'b0, 8'h00, 0);
    drain(4000);
    repeat (200) @(negedge clk);
    check("busy_count", dones - d0, 1);

    d0 = dones;
    s_msb = 8'hFF; s_lsb = 8'h00;
    fire(1'b0, 8'h00, 0);
    repeat (11 * 124 + 60) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_scl", scl, 1'b1);
    check("abort_sda", sda_w, 1'b1);
    check("abort_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    check("abort_no_done", dones - d0, 0);

    s_msb = 8'h0C; s_lsb = 8'h70;
    fire(1'b1, 8'hC7, LAT_FULL);
    drain(4000);
    check("after_abort", vol, 8'hC7);

`ifdef ADC081C021_ACK_CHECK_EN
    s_ack = 1'b0;
    fire(1'b1, 8'hC7, LAT_NACK);
    drain(2000);
    check("nack_hold", vol, 8'hC7);
    s_ack = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc081c021_read_vol.md
# adc081c021_read_vol

I2C master that reads one 8-bit conversion result from a TI ADC081C021 each time it receives a trigger pulse. It sits between a system timer, which supplies a periodic `read_trigger` (e.g. every 100 µs), and the board's I2C pins. It outputs the raw code (0..255) together with a one-cycle done strobe. Conversion to volts against the reference is done downstream.

## Interface
- `sys_clk_freq`, default 50_000_000: system clock frequency in Hz.
- `i2c_clk_speed`, default 400_000: target SCL frequency in Hz.
- `dev_addr`, default 7'h54: 7-bit slave address (ADR0 floating).
- Local constant `Q = sys_clk_freq/(i2c_clk_speed*4)`, integer division; Q = 31 at defaults.
- `sclk`  in  1  system clock; all logic on its rising edge.
- `nrst`  in  1  reset, asynchronous, active-high; registers reset while it is 1.
- `read_trigger`  in  1  one-cycle high pulse that starts one read.
- `read_done`  out  1  one-cycle high pulse when a read finishes.
- `voltage`  out  8  last captured conversion code.
- `scl`  out  1  I2C clock, driven push-pull.
- `sda`  inout  1  I2C data, open-drain: drives 0 or releases to 'z'; the board provides the pull-up.

## Operation
- Read-only transaction. The pointer register is left at its power-up value 0x00 (conversion result) and is never written.
- Bus sequence: START, {dev_addr,1'b1}, slave ACK, MSB byte, master ACK, LSB byte, master NACK, STOP.
- The slot count is 29: START, then 9 × 3, then STOP.
- Result mapping: the ADC register holds D11..D4 as its result, so `voltage = {MSB[3:0], LSB[7:4]}`. The alert bit and the reserved bits are discarded.
- FSM states: IDLE → START → ADDR (8 bits, MSB first) → ACK_A → RD_MSB (8) → MACK → RD_LSB (8) → MNACK → STOP → DONE → IDLE.
- IDLE exits only when `read_trigger`=1.
- A `read_trigger` that arrives in any state other than IDLE is ignored. It is not queued.
- On leaving DONE: `read_done` is high for exactly one cycle, and `voltage` is updated in the same cycle.
- Reset mid-transaction: the FSM returns to IDLE immediately, `scl`=1, `sda` is released, and no `read_done` is produced.

## Timing
- Every bit slot lasts 4·Q cycles and is split into quarters q0..q3, each Q cycles long.
- Data bits: `scl` is low in q0–q1 and high in q2–q3. SDA changes at the start of q1. Read bits and ACK are sampled on the last cycle of q2.
- START slot: SDA is released for q0–q1, then driven low at q2 while SCL is high. SCL falls at the end of q3.
- STOP slot: SDA is low and SCL is low for q0. SCL is high from q1. SDA is released at q2 while SCL is high.
- Idle and reset values: `scl`=1, `sda`='z', `read_done`=0, `voltage`=8'h00.
- Latency: for a trigger sampled at edge T, START begins at T+1 and `read_done` is high in cycle T+1+29·4·Q.
- At the defaults that is T+3597, about 72 µs. This is shorter than a 100 µs trigger period.
- Bit counter: 3 bits, wraps 7→0 on entry to each ACK state.
- Quarter counter: counts 0..Q-1.

## Configuration
- `ADC081C021_ACK_CHECK_EN` defined:
  - A high level sampled in ACK_A (slave NACK) jumps straight to STOP.
  - The RD states are skipped.
  - `read_done` still pulses at STOP end, with latency T+1+(1+9+1)·4·Q.
  - `voltage` keeps its previous value.
- Undefined: the ACK_A sample is ignored, and the full 29-slot sequence always runs.

## Test plan
- Reset: hold `nrst`=1 for 20 ns → `scl`=1, `sda`='z', `read_done`=0, `voltage`=0.
- Single read: a slave model ACKs and returns MSB=8'h0A, LSB=8'hB0. Pulse the trigger at T → `read_done` pulses at T+3597 and `voltage`=8'hAB. Bytes 8'hA9, ACK, NACK, STOP appear in that order on the bus.
- Periodic triggers every 5000 cycles, slave returning 8'h0F/8'hF0 → every trigger produces one `read_done` and `voltage`=8'hFF. No trigger is lost.
- Trigger at T+100 while busy → ignored. Exactly one `read_done`.
- With `ADC081C021_ACK_CHECK_EN` and a slave that leaves SDA high at ACK_A → STOP follows ACK_A, `read_done` pulses at T+1+44·Q = T+1365, and `voltage` is unchanged.
- Assert `nrst` during RD_MSB → `scl`=1 and `sda`='z' immediately. No `read_done`. The next trigger after release completes normally.
